dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits, multiple of 8, range 8..64.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 4096: word count, power of two.
REQ-004 Parameter LATENCY, default 1: cycles from acceptance to rsp_valid, range 1..8.
REQ-005 Parameter BASE_ADDR, default 0: byte address of word 0.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  write data, lane-aligned.
REQ-012 req_byteen  in  DATA_W/8  lane write enables; all-zero means read.
REQ-013 req_pc  in  32  issuing instruction address, passed to trace.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-016 rsp_rdata  out  DATA_W  word read; for writes, the merged word written.
REQ-017 rsp_err  out  1  address out of range.
REQ-018 init_done  out  1  memory clear complete.
REQ-019 trace_valid / trace_addr (ADDR_W) / trace_data (DATA_W) / trace_pc (32)  out  one-cycle write-commit record.

Function
REQ-020 FSM states: INIT, IDLE, WAIT, RESP.
REQ-021 INIT: one word zeroed per cycle, index 0..DEPTH-1; IDLE entered after the last word; init_done high from IDLE onward.
REQ-022 req_ready high only in IDLE.
REQ-023 Word index = (req_addr - BASE_ADDR) >> log2(DATA_W/8); low address bits ignored (forced alignment).
REQ-024 Index >= DEPTH or req_addr < BASE_ADDR: rsp_err=1, rsp_rdata=0, no write, no trace.
REQ-025 Acceptance: addr, wdata, byteen, and pc captured; LATENCY=1 goes directly to RESP; otherwise WAIT for LATENCY-1 cycles, counted down, then RESP.
REQ-026 rsp_valid asserted exactly LATENCY cycles after the acceptance edge; held, with data stable, until rsp_ready.
REQ-027 Write: merged word = old word with enabled lanes replaced by wdata lanes; commit on the RESP-entry edge only.
REQ-028 trace_valid pulses for one cycle on RESP entry for an in-range write; trace_addr = aligned address, trace_data = merged word, trace_pc = captured pc.
REQ-029 Read: rsp_rdata = word contents at the RESP-entry edge.
REQ-030 RESP with rsp_ready high: next state IDLE; max throughput 1 request per LATENCY+1 cycles.
REQ-031 Inputs are ignored outside IDLE; only one request is outstanding.

Reset
REQ-032 reset low at an edge: state INIT, clear index 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, trace_valid=0, init_done=0, req_ready=0.
REQ-033 Reset mid-request aborts it: uncommitted writes are dropped, no response, and the full INIT sweep is repeated.

Structure
REQ-034 Package dmem_pkg holds the state enum, LATENCY_MAX=8, and the lane-merge function.
REQ-035 Storage is the single sub-module dmem_array: one read port and one write port, synchronous write, combinational read.

Verification
REQ-036 Reset, then 4096 cycles -> init_done rises at cycle 4096; a read of 0x0 returns 0x00000000.
REQ-037 Write 0x0000000C, data 0xAABBCCDD, byteen 4'b0101 onto zero memory -> rsp_rdata 0x00BB00DD; trace_addr 0x0C, trace_data 0x00BB00DD.
REQ-038 Read of 0x0000000E after REQ-037 -> 0x00BB00DD (alignment), rsp_err=0.
REQ-039 LATENCY=4, read accepted at cycle t -> rsp_valid first high at t+4; with rsp_ready held low 3 cycles, data stable and req_ready low throughout.
REQ-040 Write to 0x00004000 with DEPTH=4096 -> rsp_err=1, rsp_rdata=0, no trace_valid, memory unchanged.
REQ-041 Reset asserted in WAIT of a write -> no trace_valid, target word reads 0 after the new INIT sweep.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package dmem_pkg;

  localparam int LATENCY_MAX = 8;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Lanes are handled at the widest supported width; callers size-cast in and out.
  function automatic logic [63:0] lane_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  lanes);
    logic [63:0] m;
    m = old_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lanes[i]) m[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_bytelane.sv
// Single-outstanding data memory with byte-lane writes, fixed response latency,
// power-up clear sweep and a write-commit trace record.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4096,
  parameter int                LATENCY   = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_byteen,
  input  logic [31:0]         req_pc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done,
  output logic                trace_valid,
  output logic [ADDR_W-1:0]   trace_addr,
  output logic [DATA_W-1:0]   trace_data,
  output logic [31:0]         trace_pc
);

  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LATENCY_MAX);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [AW-1:0]     clr_idx;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic [31:0]       pc_q;

  logic [ADDR_W-1:0] cur_addr, offset, idx_full, aligned;
  logic [DATA_W-1:0] cur_wdata, rd, merged, mem_wdata;
  logic [NB-1:0]     cur_be;
  logic [31:0]       cur_pc;
  logic [AW-1:0]     widx, mem_waddr;
  logic              oor, is_write, resp_entry, mem_we;

  // With LATENCY=1 the RESP-entry edge is the acceptance edge, so the live
  // request inputs stand in for the not-yet-captured registers while in IDLE.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    cur_pc    = pc_q;
    if (state == ST_IDLE) begin
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_byteen;
      cur_pc    = req_pc;
    end
    offset     = cur_addr - BASE_ADDR;
    idx_full   = offset >> SHIFT;
    oor        = (cur_addr < BASE_ADDR) || ({1'b0, idx_full} >= DEPTH_L);
    widx       = idx_full[AW-1:0];
    aligned    = cur_addr & ~ADDR_W'(NB - 1);
    is_write   = |cur_be;
    merged     = DATA_W'(lane_merge(64'(rd), 64'(cur_wdata), 8'(cur_be)));
    resp_entry = ((state == ST_IDLE) && req_valid && (LATENCY == 1)) ||
                 ((state == ST_WAIT) && (cnt == '0));
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wdata = merged;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = '0;
    end else if (resp_entry && is_write && !oor) begin
      mem_we = reset;
    end
  end

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (widx),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_INIT;
      clr_idx     <= '0;
      cnt         <= '0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_pc    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      pc_q        <= '0;
    end else begin
      trace_valid <= 1'b0;
      if (resp_entry) begin
        rsp_valid <= 1'b1;
        rsp_err   <= oor;
        rsp_rdata <= oor ? '0 : (is_write ? merged : rd);
        if (is_write && !oor) begin
          trace_valid <= 1'b1;
          trace_addr  <= aligned;
          trace_data  <= merged;
          trace_pc    <= cur_pc;
        end
      end
      unique case (state)
        ST_INIT: begin
          if (clr_idx == AW'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_byteen;
            pc_q      <= req_pc;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - CW'(1);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench: default-latency instance plus a LATENCY=4, DEPTH=16 instance.
module tb_dmem_bytelane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        init_done, trace_valid;
  logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata, trace_addr, trace_data, trace_pc;
  logic [3:0]  req_byteen;

  logic        reset4, v4, rq4, rv4, rr4, err4, id4, tv4;
  logic [31:0] a4, wd4, pc4, rd4, ta4, td4, tpc4;
  logic [3:0]  be4;

  dmem_bytelane dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_pc(trace_pc)
  );

  dmem_bytelane #(.DEPTH(16), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset4), .req_valid(v4), .req_ready(rq4),
    .req_addr(a4), .req_wdata(wd4), .req_byteen(be4), .req_pc(pc4),
    .rsp_valid(rv4), .rsp_ready(rr4), .rsp_rdata(rd4), .rsp_err(err4),
    .init_done(id4), .trace_valid(tv4), .trace_addr(ta4),
    .trace_data(td4), .trace_pc(tpc4)
  );

  task automatic txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] pc, output logic [31:0] rd, output logic err,
                     output logic tv, output logic [31:0] ta, output logic [31:0] td,
                     output logic [31:0] tpc, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_byteen = be; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0; req_byteen = '0;
    lat = 1; tv = 1'b0; ta = '0; td = '0; tpc = '0;
    while (!rsp_valid && lat < 20) begin
      if (trace_valid) begin tv = 1'b1; ta = trace_addr; td = trace_data; tpc = trace_pc; end
      @(negedge clk);
      lat++;
    end
    if (trace_valid) begin tv = 1'b1; ta = trace_addr; td = trace_data; tpc = trace_pc; end
    rd = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn4(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic tv, output int lat);
    @(negedge clk);
    v4 = 1'b1; a4 = addr; wd4 = wd; be4 = be; pc4 = 32'h40;
    @(negedge clk);
    v4 = 1'b0; be4 = '0;
    lat = 1; tv = 1'b0;
    while (!rv4 && lat < 20) begin
      tv = tv | tv4;
      @(negedge clk);
      lat++;
    end
    tv = tv | tv4;
    rd = rd4;
    rr4 = 1'b1;
    @(negedge clk);
    rr4 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; reset4 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0)     begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0)  begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_trace_valid got=%b exp=0", trace_valid); end
    checks++; if (init_done !== 1'b0)   begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_init;
    int n;
    logic [31:0] rd, ta, td, tpc;
    logic err, tv;
    int lat;
    reset = 1'b1; reset4 = 1'b1;
    n = 0;
    while (!init_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 4096) begin errors++; $display("FAIL init_cycles got=%0d exp=4096", n); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_req_ready got=%b exp=1", req_ready); end
    checks++; if (id4 !== 1'b1) begin errors++; $display("FAIL init4_done got=%b exp=1", id4); end
    txn(32'h0, 32'h0, 4'h0, 32'h0, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL read0_data got=%h exp=00000000", rd); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL read0_err got=%b exp=0", err); end
    checks++; if (lat !== 1)     begin errors++; $display("FAIL read0_latency got=%0d exp=1", lat); end
    checks++; if (tv !== 1'b0)   begin errors++; $display("FAIL read0_trace got=%b exp=0", tv); end
  endtask

  task automatic test_write_merge;
    logic [31:0] rd, ta, td, tpc;
    logic err, tv;
    int lat;
    txn(32'h0000000C, 32'hAABBCCDD, 4'b0101, 32'h100, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'h00BB00DD)  begin errors++; $display("FAIL wr_rdata got=%h exp=00bb00dd", rd); end
    checks++; if (tv !== 1'b1)          begin errors++; $display("FAIL wr_trace_valid got=%b exp=1", tv); end
    checks++; if (ta !== 32'h0000000C)  begin errors++; $display("FAIL wr_trace_addr got=%h exp=0000000c", ta); end
    checks++; if (td !== 32'h00BB00DD)  begin errors++; $display("FAIL wr_trace_data got=%h exp=00bb00dd", td); end
    checks++; if (tpc !== 32'h100)      begin errors++; $display("FAIL wr_trace_pc got=%h exp=00000100", tpc); end
    txn(32'h0000000E, 32'h0, 4'h0, 32'h104, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'h00BB00DD)  begin errors++; $display("FAIL align_rdata got=%h exp=00bb00dd", rd); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL align_err got=%b exp=0", err); end
    checks++; if (tv !== 1'b0)          begin errors++; $display("FAIL align_trace got=%b exp=0", tv); end
    // Unaligned full-word write, then partial overwrite of the upper lanes of bytes 1 and 3
    txn(32'h00000013, 32'h12345678, 4'b1111, 32'h108, rd, err, tv, ta, td, tpc, lat);
    checks++; if (ta !== 32'h00000010)  begin errors++; $display("FAIL full_trace_addr got=%h exp=00000010", ta); end
    checks++; if (rd !== 32'h12345678)  begin errors++; $display("FAIL full_rdata got=%h exp=12345678", rd); end
    txn(32'h00000010, 32'hA1B2C3D4, 4'b1010, 32'h10C, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'hA134C378)  begin errors++; $display("FAIL merge2_rdata got=%h exp=a134c378", rd); end
    txn(32'h00000010, 32'h0, 4'h0, 32'h110, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'hA134C378)  begin errors++; $display("FAIL merge2_read got=%h exp=a134c378", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, ta, td, tpc;
    logic err, tv;
    int lat;
    txn(32'h00004000, 32'hFFFFFFFF, 4'hF, 32'h200, rd, err, tv, ta, td, tpc, lat);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL oor_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL oor_rdata got=%h exp=0", rd); end
    checks++; if (tv !== 1'b0)   begin errors++; $display("FAIL oor_trace got=%b exp=0", tv); end
    txn(32'h00000000, 32'h0, 4'h0, 32'h204, rd, err, tv, ta, td, tpc, lat);
    checks++; if (rd !== 32'h0)  begin errors++; $display("FAIL oor_alias_word0 got=%h exp=0", rd); end
    txn(32'h00003FFC, 32'h0, 4'h0, 32'h208, rd, err, tv, ta, td, tpc, lat);
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL last_word_err got=%b exp=0", err); end
  endtask

  task automatic test_back_to_back;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000000C; req_byteen = 4'h0; rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen++;
        checks++; if (rsp_rdata !== 32'h00BB00DD) begin errors++; $display("FAIL b2b_rdata got=%h exp=00bb00dd", rsp_rdata); end
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (seen !== 3) begin errors++; $display("FAIL b2b_responses got=%0d exp=3", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", req_ready); end
  endtask

  task automatic test_latency;
    logic [31:0] rd, held;
    logic tv;
    int lat, n;
    txn4(32'h4, 32'hCAFEF00D, 4'hF, rd, tv, lat);
    checks++; if (tv !== 1'b1) begin errors++; $display("FAIL lat4_wr_trace got=%b exp=1", tv); end
    @(negedge clk);
    checks++; if (rq4 !== 1'b1) begin errors++; $display("FAIL lat4_ready_idle got=%b exp=1", rq4); end
    v4 = 1'b1; a4 = 32'h4; be4 = 4'h0;
    @(negedge clk);
    v4 = 1'b0;
    n = 1;
    while (!rv4 && n < 20) begin
      checks++; if (rq4 !== 1'b0) begin errors++; $display("FAIL lat4_ready_wait got=%b exp=0", rq4); end
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL lat4_latency got=%0d exp=4", n); end
    held = rd4;
    checks++; if (held !== 32'hCAFEF00D) begin errors++; $display("FAIL lat4_rdata got=%h exp=cafef00d", held); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rv4 !== 1'b1)  begin errors++; $display("FAIL lat4_hold_valid got=%b exp=1", rv4); end
      checks++; if (rd4 !== held)  begin errors++; $display("FAIL lat4_hold_data got=%h exp=%h", rd4, held); end
      checks++; if (rq4 !== 1'b0)  begin errors++; $display("FAIL lat4_hold_ready got=%b exp=0", rq4); end
    end
    rr4 = 1'b1;
    @(negedge clk);
    rr4 = 1'b0;
    checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL lat4_consumed got=%b exp=0", rv4); end
    checks++; if (rq4 !== 1'b1) begin errors++; $display("FAIL lat4_ready_back got=%b exp=1", rq4); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd;
    logic tv, seen_tv, seen_rv;
    int lat, n;
    @(negedge clk);
    v4 = 1'b1; a4 = 32'h8; wd4 = 32'hFFFFFFFF; be4 = 4'hF;
    @(negedge clk);
    v4 = 1'b0; be4 = '0;
    reset4 = 1'b0;
    seen_tv = 1'b0; seen_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_tv = seen_tv | tv4; seen_rv = seen_rv | rv4;
    end
    checks++; if (id4 !== 1'b0) begin errors++; $display("FAIL rstwait_init_done got=%b exp=0", id4); end
    reset4 = 1'b1;
    n = 0;
    while (!id4 && n < 100) begin
      @(negedge clk);
      seen_tv = seen_tv | tv4; seen_rv = seen_rv | rv4;
      n++;
    end
    checks++; if (n !== 16)       begin errors++; $display("FAIL rstwait_sweep got=%0d exp=16", n); end
    checks++; if (seen_tv !== 1'b0) begin errors++; $display("FAIL rstwait_trace got=%b exp=0", seen_tv); end
    checks++; if (seen_rv !== 1'b0) begin errors++; $display("FAIL rstwait_rsp got=%b exp=0", seen_rv); end
    txn4(32'h8, 32'h0, 4'h0, rd, tv, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstwait_word8 got=%h exp=0", rd); end
    txn4(32'h4, 32'h0, 4'h0, rd, tv, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstwait_word4 got=%h exp=0", rd); end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_byteen = '0; req_pc = '0; rsp_ready = 1'b0;
    v4 = 1'b0; a4 = '0; wd4 = '0; be4 = '0; pc4 = '0; rr4 = 1'b0;
    reset = 1'b0; reset4 = 1'b0;
    test_reset;
    test_init;
    test_write_merge;
    test_out_of_range;
    test_back_to_back;
    test_latency;
    test_reset_in_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
